// File: rtl/support_sequencer_if.sv
// rtl/support_sequencer_if.sv - board pin / CPU support signal bundle for support_sequencer
interface support_sequencer_if;
    logic       button_r;
    logic       button_b;
    logic       button_h;
    logic       button_c;
    logic       dcm_locked;
    logic       dcm_reset;
    logic       reset;
    logic       interrupt;
    logic       boot;
    logic       halt;
    logic [2:0] state_dbg;

    modport master (
        input  button_r, button_b, button_h, button_c, dcm_locked,
        output dcm_reset, reset, interrupt, boot, halt, state_dbg
    );

    modport slave (
        output button_r, button_b, button_h, button_c, dcm_locked,
        input  dcm_reset, reset, interrupt, boot, halt, state_dbg
    );
endinterface

// File: rtl/support_sequencer.sv
// rtl/support_sequencer.sv - button debounce plus DCM/CPU reset and boot sequencing
module support_sequencer #(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int DCM_RESET_CYCLES = 8,
    parameter int RESET_CYCLES     = 100,
    parameter int BOOT_CYCLES      = 16
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    support_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        DCM_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        CPU_RST   = 3'd2,
        BOOT      = 3'd3,
        RUN       = 3'd4
    } state_t;

    // One shared sequencing counter, wide enough for the longest phase.
    localparam int SEQ_MAX = (DCM_RESET_CYCLES > RESET_CYCLES) ?
                             ((DCM_RESET_CYCLES > BOOT_CYCLES) ? DCM_RESET_CYCLES : BOOT_CYCLES) :
                             ((RESET_CYCLES > BOOT_CYCLES) ? RESET_CYCLES : BOOT_CYCLES);
    localparam int SW  = $clog2(SEQ_MAX > 1 ? SEQ_MAX : 2);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);

    localparam logic [SW-1:0]  DCM_LAST  = SW'(DCM_RESET_CYCLES - 1);
    localparam logic [SW-1:0]  RST_LAST  = SW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0]  BOOT_LAST = SW'(BOOT_CYCLES - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

    // Bit 4 is dcm_locked; bits 3:0 are buttons c, h, b, r.
    logic [4:0]     raw_in;
    logic [4:0]     sync1;
    logic [4:0]     sync2;
    logic [3:0]     db_level;
    logic [DBW-1:0] db_cnt [4];
    logic [3:0]     db_done;
    logic [3:0]     press;
    logic           lock_s;

    state_t         state, state_nx;
    logic [SW-1:0]  seq_cnt, seq_cnt_nx;
    logic           boot_pending, boot_pending_nx;
    logic           halt_q, halt_nx;
    logic           dcm_reset_q, reset_q, boot_q;

    assign raw_in = {bus.dcm_locked, bus.button_c, bus.button_h, bus.button_b, bus.button_r};
    assign lock_s = sync2[4];

    // Two-flop synchronizers for every asynchronous board input.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // A level change is accepted on the last of DEBOUNCE_CYCLES stable cycles; rising acceptance is a press.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_done[i] = (sync2[i] != db_level[i]) && (db_cnt[i] == DB_LAST);
            press[i]   = db_done[i] && sync2[i];
        end
    end

    // Per-button stability counters and debounced levels.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            db_level <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_done[i]) begin
                    db_level[i] <= ~db_level[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Next-state logic: lock loss outranks buttons, buttons are only honoured in RUN with r > b > h > c.
    always_comb begin
        state_nx        = state;
        seq_cnt_nx      = seq_cnt;
        boot_pending_nx = boot_pending;
        halt_nx         = halt_q;
        case (state)
            DCM_RST: begin
                if (seq_cnt == DCM_LAST) begin
                    state_nx   = WAIT_LOCK;
                    seq_cnt_nx = '0;
                end else begin
                    seq_cnt_nx = seq_cnt + SW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx   = CPU_RST;
                    seq_cnt_nx = '0;
                end
            end
            CPU_RST, BOOT: begin
                if (!lock_s) begin
                    state_nx        = DCM_RST;
                    seq_cnt_nx      = '0;
                    boot_pending_nx = 1'b1;
                end else if (state == CPU_RST && seq_cnt == RST_LAST) begin
                    state_nx   = boot_pending ? BOOT : RUN;
                    seq_cnt_nx = '0;
                end else if (state == BOOT && seq_cnt == BOOT_LAST) begin
                    state_nx        = RUN;
                    seq_cnt_nx      = '0;
                    boot_pending_nx = 1'b0;
                end else begin
                    seq_cnt_nx = seq_cnt + SW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx        = DCM_RST;
                    seq_cnt_nx      = '0;
                    boot_pending_nx = 1'b1;
                end else if (press[0]) begin
                    state_nx        = CPU_RST;
                    seq_cnt_nx      = '0;
                    boot_pending_nx = 1'b0;
                end else if (press[1]) begin
                    state_nx        = CPU_RST;
                    seq_cnt_nx      = '0;
                    boot_pending_nx = 1'b1;
                end else if (press[2]) begin
                    halt_nx = 1'b1;
                end else if (press[3]) begin
                    halt_nx = 1'b0;
                end
            end
            default: begin
                state_nx        = DCM_RST;
                seq_cnt_nx      = '0;
                boot_pending_nx = 1'b1;
            end
        endcase
        // Halt only has meaning while the CPU is running.
        if (state_nx != RUN) halt_nx = 1'b0;
    end

    // State, counter and registered outputs all update on the same edge.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= DCM_RST;
            seq_cnt      <= '0;
            boot_pending <= 1'b1;
            halt_q       <= 1'b0;
            dcm_reset_q  <= 1'b1;
            reset_q      <= 1'b1;
            boot_q       <= 1'b0;
        end else begin
            state        <= state_nx;
            seq_cnt      <= seq_cnt_nx;
            boot_pending <= boot_pending_nx;
            halt_q       <= halt_nx;
            dcm_reset_q  <= (state_nx == DCM_RST);
            reset_q      <= (state_nx == DCM_RST) || (state_nx == WAIT_LOCK) || (state_nx == CPU_RST);
            boot_q       <= (state_nx == BOOT);
        end
    end

    assign bus.dcm_reset = dcm_reset_q;
    assign bus.reset     = reset_q;
    assign bus.boot      = boot_q;
    assign bus.halt      = halt_q;
    assign bus.interrupt = 1'b0;
    assign bus.state_dbg = state;

endmodule

// File: doc/support_sequencer.md
Name: support_sequencer

Overview:
- Synthesizable board-support controller that replaces the simulation-only support stimulus.
- Debounces the four front-panel buttons (r, b, h, c).
- Sequences the DCM reset, CPU reset and boot strobe after power-up, after DCM lock loss and on button request.
- Drives the CPU halt line.
- Sits between the board pins/DCM and the CPU top level; its output names match the existing support interface.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable sysclk cycles required before a button level change is accepted.
- DCM_RESET_CYCLES, 8: sysclk cycles dcm_reset is held high.
- RESET_CYCLES, 100: sysclk cycles the CPU reset is held high after lock.
- BOOT_CYCLES, 16: sysclk cycles boot is held high.

Ports:
- sysclk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- button_r  in  1  raw reset button, async, active high.
- button_b  in  1  raw boot button, async, active high.
- button_h  in  1  raw halt button, async, active high.
- button_c  in  1  raw continue button, async, active high.
- dcm_locked  in  1  DCM lock indicator, async.
- dcm_reset  out  1  DCM reset.
- reset  out  1  CPU reset, active high.
- interrupt  out  1  CPU interrupt request.
- boot  out  1  CPU boot strobe.
- halt  out  1  CPU halt level.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n). While reset_n=0:
  - dcm_reset=1, reset=1, boot=0, halt=0, interrupt=0.
  - state=DCM_RST, counters=0, boot_pending=1.
  - Debounced levels=0, sync flops=0.
- Synchronizers: each button and dcm_locked pass through a 2-FF synchronizer.
- Debounce, per button:
  - The counter increments while the synced level differs from the debounced level; it clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A press is a one-cycle pulse on the debounced 0->1 edge. Releases generate no event.
- Width rule: counters are sized by clog2 of their parameter. Defaults must be >=1. Counters never wrap; they stop at terminal count.
- FSM states and encoding:
  - DCM_RST=0: dcm_reset=1, reset=1. After DCM_RESET_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK=1: dcm_reset=0, reset=1. When synced lock=1 -> CPU_RST, counter cleared. No timeout.
  - CPU_RST=2: reset=1, halt forced 0. After RESET_CYCLES cycles -> BOOT if boot_pending, else RUN.
  - BOOT=3: reset=0, boot=1. After BOOT_CYCLES cycles -> RUN; boot_pending cleared.
  - RUN=4: reset=0, boot=0. Button events are acted on only in this state.
- Outputs are registered: each output changes in the same cycle as the state register. A press pulse in cycle N gives the new state and outputs in cycle N+1.
- RUN events, priority r > b > h > c when simultaneous:
  - r -> CPU_RST, boot_pending=0.
  - b -> CPU_RST, boot_pending=1.
  - h -> halt=1, state unchanged.
  - c -> halt=0, state unchanged.
  - h while already halted, or c while not halted: no effect.
- Press events in any state other than RUN are discarded, not queued.
- Lock loss: synced dcm_locked=0 in CPU_RST, BOOT or RUN -> DCM_RST with counter cleared, boot_pending=1, halt=0. This has priority over button events in the same cycle.
- interrupt is held 0 in all states and is reserved.
- reset_n assertion mid-sequence returns asynchronously to reset values. The full power-up sequence, including BOOT, runs again after release.

Test Plan (DEBOUNCE=4, DCM_RESET=4, RESET=10, BOOT=3; dcm_locked tied 1):
- Power-up: release reset_n -> dcm_reset high 4 cycles, then reset high 10 cycles after lock seen, then boot high exactly 3 cycles; state_dbg ends at 4 with reset=0, boot=0, halt=0.
- Bounce: in RUN, toggle button_h every 2 cycles for 20 cycles, then hold high -> no halt change while toggling; halt=1 exactly 4+2 cycles after the stable level (2 sync + 4 debounce), one cycle later state-wise.
- Halt/continue: press h then c in RUN -> halt 0->1->0; a second c press leaves halt 0; state_dbg stays 4 throughout.
- Reset vs boot buttons: press r -> reset high 10 cycles, boot never asserted; press b -> reset high 10 cycles then boot high 3 cycles. Press r and b in the same debounced cycle -> r wins, no boot.
- Lock loss: drop dcm_locked in RUN with halt=1 -> within 3 cycles state_dbg=0, halt=0, dcm_reset=1; reassert lock -> full sequence including boot.
- Mid-sequence reset: assert reset_n low during BOOT -> boot=0 and dcm_reset=1 immediately (asynchronously); release -> full sequence repeats. A press during CPU_RST is ignored.
